addr_mode_sequencer: RTL and testbench
======================================

ADDR_MODE_SEQUENCER -- requirements
Module: addr_mode_sequencer

Interface
REQ-001 Reset is synchronous and active-high; one clock, all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 data_in  input  8  external data bus; holds the opcode byte during FETCH.
REQ-005 rdy  input  1  bus ready; low stalls the sequencer (see Configuration).
REQ-006 carry_from_low_op  input  1  ALU carry out of the Indirect-Y low-byte add.
REQ-007 exec_done  input  1  instruction logic finished its execute cycles.
REQ-008 state  output  5  current cycle: FETCH=0, A0=1, A1=2, A2=3, A3=4, EXEC=5.
REQ-009 mode  output  4  decoded mode: IMPL=0, IMM=1, ZPG=2, ZPG_X=3, ZPG_Y=4, ABS=5, ABS_X=6, ABS_Y=7, IND_X=8, IND_Y=9.
REQ-010 opcode_q  output  8  latched opcode of the current instruction.
REQ-011 fetch  output  1  high exactly when state==FETCH.
REQ-012 carry_to_high_op  output  1  registered page-cross carry for the Indirect-Y high-byte add.

Function
REQ-013 Address-cycle count per mode: IMPL 0, IMM 0, ZPG 1, ZPG_X 2, ZPG_Y 2, ABS 2, ABS_X 3, ABS_Y 3, IND_X 4, IND_Y 4.
REQ-014 Decode from data_in (cc=bits1:0, bbb=bits4:2), cc=01: bbb 000 IND_X, 001 ZPG, 010 IMM, 011 ABS, 100 IND_Y, 101 ZPG_X, 110 ABS_Y, 111 ABS_X.
REQ-015 cc=10: bbb 000 IMM, 001 ZPG, 011 ABS, 101 ZPG_X (ZPG_Y for 0x96, 0xB6), 111 ABS_X (ABS_Y for 0xBE), others IMPL.
REQ-016 cc=00: bbb 001 ZPG, 011 ABS, 100 IMM, 101 ZPG_X, 111 ABS_X; bbb 000 is IMM for 0xA0/0xC0/0xE0, ABS for 0x20, else IMPL; others IMPL.
REQ-017 cc=11 decodes as IMPL with 0 address cycles.
REQ-018 In FETCH with advance enabled: opcode_q<=data_in, mode<=decode(data_in), state<=A0 if count>0 else EXEC.
REQ-019 In A(n): state<=A(n+1) if n+1<count else EXEC; each A-state lasts exactly one advancing cycle.
REQ-020 In EXEC: state<=FETCH when exec_done==1, else hold EXEC; exec_done ignored in all other states.
REQ-021 opcode_q and mode change only on the FETCH->next transition; stable through A- and EXEC states.
REQ-022 carry_to_high_op<=carry_from_low_op when state==A1 and mode==IND_Y and advancing; cleared when leaving FETCH; held otherwise.
REQ-023 Latency: ZPG instruction with exec_done tied high occupies FETCH, A0, EXEC = 3 cycles; IMPL occupies FETCH, EXEC = 2 cycles.
REQ-024 State encodings 6..31 unreachable; if entered, next state is FETCH.

Reset
REQ-025 While rst==1 at a clock edge: state=FETCH, mode=IMPL, opcode_q=0x00, carry_to_high_op=0; fetch=1 in the following cycle.
REQ-026 Reset mid-instruction (any state) aborts it; rst overrides rdy and exec_done.

Configuration
REQ-027 Macro ADDR_SEQ_RDY_STALL_EN defined: rdy==0 freezes state, opcode_q, mode, carry_to_high_op (no advance, exec_done and carry sampling suppressed).
REQ-028 Macro undefined: rdy port present but ignored; sequencer advances every cycle.

Verification
REQ-029 rst 1 cycle -> state=0, mode=0, opcode_q=0x00, fetch=1, carry_to_high_op=0.
REQ-030 data_in=0xA5 (LDA zpg), exec_done=1 -> states 0,1,5,0; mode=2; opcode_q=0xA5.
REQ-031 data_in=0xB1 (LDA (zp),Y), carry_from_low_op=1 only during A1 -> states 0,1,2,3,4,5; carry_to_high_op=1 from A2 onward, 0 after next FETCH exit.
REQ-032 data_in=0xBE -> mode=7, states 0,1,2,3,5; data_in=0xB6 -> mode=4, states 0,1,2,5.
REQ-033 data_in=0xEA, exec_done low 3 cycles then high -> EXEC held 4 cycles, then FETCH; rst asserted in A1 of 0x7D -> FETCH next cycle.
REQ-034 With ADDR_SEQ_RDY_STALL_EN, rdy=0 two cycles during A1 of 0xBD -> A1 held 3 cycles, outputs unchanged; without macro, no stall.

Source files
------------

// File: rtl/addr_mode_sequencer.sv
// addr_mode_sequencer: per-instruction cycle sequencer for a 6502-style core.
// Latches the opcode in FETCH, decodes its addressing mode, steps through the
// mode's address cycles (A0..A3) and waits in EXEC until the instruction logic
// reports completion. Also registers the Indirect-Y page-cross carry.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   data_in[7:0]       data bus, opcode byte during FETCH
//   rdy                bus ready (stalls only when ADDR_SEQ_RDY_STALL_EN)
//   carry_from_low_op  ALU carry from the Indirect-Y low-byte add
//   exec_done          instruction logic finished execute
//   state[4:0]         current cycle (FETCH=0, A0..A3=1..4, EXEC=5)
//   mode[3:0]          decoded addressing mode of the current instruction
//   opcode_q[7:0]      latched opcode
//   fetch              high while state==FETCH
//   carry_to_high_op   registered carry for the Indirect-Y high-byte add
//
// Optional feature: define ADDR_SEQ_RDY_STALL_EN to let rdy==0 freeze the
// sequencer; otherwise rdy is ignored and the sequencer advances every cycle.

module addr_mode_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       rdy,
    input  logic       carry_from_low_op,
    input  logic       exec_done,
    output logic [4:0] state,
    output logic [3:0] mode,
    output logic [7:0] opcode_q,
    output logic       fetch,
    output logic       carry_to_high_op
);

    localparam int unsigned STATE_W = 5;
    localparam int unsigned MODE_W  = 4;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH = 5'd0,
        ST_A0    = 5'd1,
        ST_A1    = 5'd2,
        ST_A2    = 5'd3,
        ST_A3    = 5'd4,
        ST_EXEC  = 5'd5
    } state_t;

    typedef enum logic [MODE_W-1:0] {
        M_IMPL  = 4'd0,
        M_IMM   = 4'd1,
        M_ZPG   = 4'd2,
        M_ZPG_X = 4'd3,
        M_ZPG_Y = 4'd4,
        M_ABS   = 4'd5,
        M_ABS_X = 4'd6,
        M_ABS_Y = 4'd7,
        M_IND_X = 4'd8,
        M_IND_Y = 4'd9
    } mode_t;

    // Addressing mode from the opcode's cc/bbb fields plus the few irregular opcodes.
    function automatic mode_t decode(input logic [7:0] op);
        mode_t m;
        m = M_IMPL;
        case (op[1:0])
            2'b01: begin
                case (op[4:2])
                    3'b000:  m = M_IND_X;
                    3'b001:  m = M_ZPG;
                    3'b010:  m = M_IMM;
                    3'b011:  m = M_ABS;
                    3'b100:  m = M_IND_Y;
                    3'b101:  m = M_ZPG_X;
                    3'b110:  m = M_ABS_Y;
                    default: m = M_ABS_X;
                endcase
            end
            2'b10: begin
                case (op[4:2])
                    3'b000:  m = M_IMM;
                    3'b001:  m = M_ZPG;
                    3'b011:  m = M_ABS;
                    3'b101:  m = (op == 8'h96 || op == 8'hB6) ? M_ZPG_Y : M_ZPG_X;
                    3'b111:  m = (op == 8'hBE) ? M_ABS_Y : M_ABS_X;
                    default: m = M_IMPL;
                endcase
            end
            2'b00: begin
                case (op[4:2])
                    3'b000: begin
                        if (op == 8'hA0 || op == 8'hC0 || op == 8'hE0) m = M_IMM;
                        else if (op == 8'h20)                          m = M_ABS;
                        else                                           m = M_IMPL;
                    end
                    3'b001:  m = M_ZPG;
                    3'b011:  m = M_ABS;
                    3'b100:  m = M_IMM;
                    3'b101:  m = M_ZPG_X;
                    3'b111:  m = M_ABS_X;
                    default: m = M_IMPL;
                endcase
            end
            default: m = M_IMPL;
        endcase
        return m;
    endfunction

    // Number of address cycles each mode spends between FETCH and EXEC.
    function automatic logic [CNT_W-1:0] addr_cycles(input mode_t m);
        logic [CNT_W-1:0] n;
        case (m)
            M_ZPG:                    n = 3'd1;
            M_ZPG_X, M_ZPG_Y, M_ABS:  n = 3'd2;
            M_ABS_X, M_ABS_Y:         n = 3'd3;
            M_IND_X, M_IND_Y:         n = 3'd4;
            default:                  n = 3'd0;
        endcase
        return n;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    mode_t            mode_q;
    mode_t            op_mode;
    logic             adv;
    logic [CNT_W-1:0] cycles;

`ifdef ADDR_SEQ_RDY_STALL_EN
    assign adv = rdy;
`else
    logic unused_rdy;
    assign unused_rdy = rdy;
    assign adv        = 1'b1;
`endif

    assign op_mode = decode(data_in);
    assign cycles  = addr_cycles(mode_q);

    // Next-state logic. A(n) is encoded as n+1, so the state value itself is
    // the number of address cycles completed once this one finishes.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_FETCH: begin
                if (adv) state_nxt = (addr_cycles(op_mode) != 3'd0) ? ST_A0 : ST_EXEC;
            end
            ST_A0, ST_A1, ST_A2, ST_A3: begin
                if (adv) state_nxt = (CNT_W'(state_q) < cycles)
                                   ? state_t'(STATE_W'(state_q) + 5'd1) : ST_EXEC;
            end
            ST_EXEC: begin
                if (adv && exec_done) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // Sequencer registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_FETCH;
            mode_q           <= M_IMPL;
            opcode_q         <= 8'h00;
            fetch            <= 1'b1;
            carry_to_high_op <= 1'b0;
        end else begin
            state_q <= state_nxt;
            fetch   <= (state_nxt == ST_FETCH);
            if (adv && state_q == ST_FETCH) begin
                opcode_q         <= data_in;
                mode_q           <= op_mode;
                carry_to_high_op <= 1'b0;
            end
            if (adv && state_q == ST_A1 && mode_q == M_IND_Y) begin
                carry_to_high_op <= carry_from_low_op;
            end
        end
    end

    assign state = STATE_W'(state_q);
    assign mode  = MODE_W'(mode_q);

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb_addr_mode_sequencer: scoreboard bench for addr_mode_sequencer. Each step
// pushes the expected post-edge outputs, clocks once, then pops and compares.

module tb_addr_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       rdy;
    logic       carry_from_low_op;
    logic       exec_done;
    logic [4:0] state;
    logic [3:0] mode;
    logic [7:0] opcode_q;
    logic       fetch;
    logic       carry_to_high_op;

    typedef struct {
        logic [4:0] st;
        logic [3:0] md;
        logic [7:0] op;
        logic       cy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    addr_mode_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .rdy               (rdy),
        .carry_from_low_op (carry_from_low_op),
        .exec_done         (exec_done),
        .state             (state),
        .mode              (mode),
        .opcode_q          (opcode_q),
        .fetch             (fetch),
        .carry_to_high_op  (carry_to_high_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Address-cycle count per mode, straight from the mode table.
    function automatic int cyc_of(input logic [3:0] md);
        case (md)
            4'd2:       return 1;
            4'd3, 4'd4, 4'd5: return 2;
            4'd6, 4'd7: return 3;
            4'd8, 4'd9: return 4;
            default:    return 0;
        endcase
    endfunction

    task automatic step(input logic r, input logic [7:0] d, input logic ed, input logic cl,
                        input logic rd, input logic [4:0] es, input logic [3:0] em,
                        input logic [7:0] eo, input logic ec);
        exp_t e;
        e.st = es; e.md = em; e.op = eo; e.cy = ec;
        sb.push_back(e);
        rst = r; data_in = d; exec_done = ed; carry_from_low_op = cl; rdy = rd;
        @(posedge clk);
        #1;
        check_eq("sb_empty", 32'(sb.size() == 0), 32'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("state", 32'(state), 32'(e.st));
            check_eq("mode", 32'(mode), 32'(e.md));
            check_eq("opcode_q", 32'(opcode_q), 32'(e.op));
            check_eq("fetch", 32'(fetch), 32'(e.st == 5'd0));
            check_eq("carry", 32'(carry_to_high_op), 32'(e.cy));
        end
    endtask

    // Full instruction with exec_done high and junk on the bus after FETCH.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] md);
        int n;
        n = cyc_of(md);
        step(1'b0, op, 1'b1, 1'b0, 1'b1, (n > 0) ? 5'd1 : 5'd5, md, op, 1'b0);
        if (n > 0) begin
            for (int i = 1; i < n; i++)
                step(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1, 5'(i + 1), md, op, 1'b0);
            step(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1, 5'd5, md, op, 1'b0);
        end
        step(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1, 5'd0, md, op, 1'b0);
    endtask

    logic [7:0] sweep_op [32] = '{8'hA9, 8'hA1, 8'hAD, 8'hB9, 8'hB5, 8'hA2, 8'hA6, 8'h0A,
                                  8'hAE, 8'hB6, 8'h96, 8'h95, 8'hBE, 8'hFE, 8'hF6, 8'hA0,
                                  8'hC0, 8'hE0, 8'h20, 8'h00, 8'h40, 8'h24, 8'h2C, 8'h10,
                                  8'hB4, 8'hBC, 8'h08, 8'h18, 8'hFF, 8'hA7, 8'hB2, 8'h9A};
    logic [3:0] sweep_md [32] = '{4'd1, 4'd8, 4'd5, 4'd7, 4'd3, 4'd1, 4'd2, 4'd0,
                                  4'd5, 4'd4, 4'd4, 4'd3, 4'd7, 4'd6, 4'd3, 4'd1,
                                  4'd1, 4'd1, 4'd5, 4'd0, 4'd0, 4'd2, 4'd5, 4'd1,
                                  4'd3, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    initial begin
        rst = 1'b1; data_in = 8'h00; rdy = 1'b1; carry_from_low_op = 1'b0; exec_done = 1'b0;

        // Reset, with stray inputs active that reset must override.
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 8'h00, 1'b0);

        // LDA zpg: FETCH, A0, EXEC, FETCH.
        step(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 5'd1, 4'd2, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd5, 4'd2, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 4'd2, 8'hA5, 1'b0);

        // LDA (zp),Y with carry only during A1.
        step(1'b0, 8'hB1, 1'b0, 1'b0, 1'b1, 5'd1, 4'd9, 8'hB1, 1'b0);
        step(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 5'd2, 4'd9, 8'hB1, 1'b0);
        step(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 5'd3, 4'd9, 8'hB1, 1'b1);
        step(1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 5'd4, 4'd9, 8'hB1, 1'b1);
        step(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 5'd5, 4'd9, 8'hB1, 1'b1);
        step(1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 5'd0, 4'd9, 8'hB1, 1'b1);

        // NOP: carry clears on FETCH exit; EXEC held 4 cycles; carry input ignored.
        step(1'b0, 8'hEA, 1'b0, 1'b1, 1'b1, 5'd5, 4'd0, 8'hEA, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 8'h66, 1'b0, 1'b1, 1'b1, 5'd5, 4'd0, 8'hEA, 1'b0);
        step(1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 5'd0, 4'd0, 8'hEA, 1'b0);

        // Indirect-X ignores carry input even in A1.
        step(1'b0, 8'hA1, 1'b1, 1'b1, 1'b1, 5'd1, 4'd8, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd2, 4'd8, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd3, 4'd8, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd4, 4'd8, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 5'd5, 4'd8, 8'hA1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 4'd8, 8'hA1, 1'b0);

        // LDX abs,Y and LDX zp,Y.
        run_instr(8'hBE, 4'd7);
        run_instr(8'hB6, 4'd4);

        // Reset in A1 of ADC abs,X aborts the instruction.
        step(1'b0, 8'h7D, 1'b1, 1'b0, 1'b1, 5'd1, 4'd6, 8'h7D, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd2, 4'd6, 8'h7D, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 4'd0, 8'h00, 1'b0);

        // rdy low for two cycles in A1 of LDA abs,X.
        step(1'b0, 8'hBD, 1'b1, 1'b0, 1'b1, 5'd1, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd2, 4'd6, 8'hBD, 1'b0);
`ifdef ADDR_SEQ_RDY_STALL_EN
        step(1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 5'd2, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 5'd2, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd3, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd5, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd5, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 4'd6, 8'hBD, 1'b0);
`else
        step(1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 5'd3, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 5'd5, 4'd6, 8'hBD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 4'd6, 8'hBD, 1'b0);
`endif

        // Decode sweep across all cc groups and the irregular opcodes.
        for (int i = 0; i < 32; i++) run_instr(sweep_op[i], sweep_md[i]);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
